// File: rtl/regfile_exec_unit_pkg.sv
// Shared widths, opcodes and saturation limits for the register-file/execute slice.
package regfile_exec_unit_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_CNT    = 16;
  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_XOR  = 3'b011,
    OP_RED  = 3'b100
  } op_t;

endpackage

// File: rtl/regfile_exec_unit_exec_alu.sv
// Combinational execute stage: saturating add/sub, NAND, XOR and signed byte reduction.
module regfile_exec_unit_exec_alu
  import regfile_exec_unit_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  op_t               op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              error_o
);

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;
  logic              ovf;
  logic [8:0]        red_hi;
  logic [8:0]        red_lo;
  logic [9:0]        red_tot;

  // SUB reuses the adder as A + ~B + 1, so one overflow rule covers both.
  assign is_sub = (op_i == OP_SUB);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign sum    = a_i + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
  assign ovf    = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);

  assign red_hi  = {a_i[15], a_i[15:8]} + {b_i[15], b_i[15:8]};
  assign red_lo  = {a_i[7], a_i[7:0]} + {b_i[7], b_i[7:0]};
  assign red_tot = {red_hi[8], red_hi} + {red_lo[8], red_lo};

  always_comb begin
    result_o = '0;
    error_o  = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        error_o  = ovf;
        result_o = ovf ? (a_i[DATA_W-1] ? SAT_NEG : SAT_POS) : sum;
      end
      OP_NAND: result_o = ~(a_i & b_i);
      OP_XOR:  result_o = a_i ^ b_i;
      OP_RED:  result_o = {{(DATA_W-10){red_tot[9]}}, red_tot};
      default: begin
        result_o = '0;
        error_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_exec_unit.sv
// 16x16 register file (R0 hardwired to zero) with write-before-read bypass feeding the ALU.
module regfile_exec_unit
  import regfile_exec_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] src_reg1,
  input  logic [REG_ADDR_W-1:0] src_reg2,
  input  logic [REG_ADDR_W-1:0] dst_reg,
  input  logic                  write_reg,
  input  logic                  wb_sel,
  input  logic [DATA_W-1:0]     dst_data,
  input  logic [2:0]            op,
  output logic [DATA_W-1:0]     src_data1,
  output logic [DATA_W-1:0]     src_data2,
  output logic [DATA_W-1:0]     exec_result,
  output logic                  exec_error
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              wr_en;
  logic              byp1;
  logic              byp2;

  assign wr_en = rst_n && write_reg && (dst_reg != '0);
  assign wd    = wb_sel ? exec_result : dst_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_CNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[dst_reg] <= wd;
    end
  end

  assign rd1 = (src_reg1 == '0) ? '0 : regs_q[src_reg1];
  assign rd2 = (src_reg2 == '0) ? '0 : regs_q[src_reg2];

  // Result write-back is never bypassed: it would feed the ALU output back into its own inputs.
  assign byp1 = wr_en && !wb_sel && (dst_reg == src_reg1);
  assign byp2 = wr_en && !wb_sel && (dst_reg == src_reg2);

  assign src_data1 = byp1 ? dst_data : rd1;
  assign src_data2 = byp2 ? dst_data : rd2;

  regfile_exec_unit_exec_alu u_exec_alu (
    .a_i      (src_data1),
    .b_i      (src_data2),
    .op_i     (op_t'(op)),
    .result_o (exec_result),
    .error_o  (exec_error)
  );

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Directed self-checking bench for regfile_exec_unit with hand-computed expectations.
module tb_regfile_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_reg1;
  logic [3:0]  src_reg2;
  logic [3:0]  dst_reg;
  logic        write_reg;
  logic        wb_sel;
  logic [15:0] dst_data;
  logic [2:0]  op;
  logic [15:0] src_data1;
  logic [15:0] src_data2;
  logic [15:0] exec_result;
  logic        exec_error;

  int n_total = 0;
  int n_bad   = 0;

  regfile_exec_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_reg1    (src_reg1),
    .src_reg2    (src_reg2),
    .dst_reg     (dst_reg),
    .write_reg   (write_reg),
    .wb_sel      (wb_sel),
    .dst_data    (dst_data),
    .op          (op),
    .src_data1   (src_data1),
    .src_data2   (src_data2),
    .exec_result (exec_result),
    .exec_error  (exec_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one register through the external data path, then release the write.
  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    dst_reg   = addr;
    dst_data  = data;
    wb_sel    = 1'b0;
    write_reg = 1'b1;
    @(posedge clk);
    #1;
    write_reg = 1'b0;
  endtask

  task automatic alu_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] opv, input logic [15:0] exp_r, input logic exp_e);
    wr(4'd1, a);
    wr(4'd2, b);
    src_reg1 = 4'd1;
    src_reg2 = 4'd2;
    op       = opv;
    #1;
    check({tag, "_res"}, exec_result, exp_r);
    check({tag, "_err"}, {15'b0, exec_error}, {15'b0, exp_e});
  endtask

  initial begin
    rst_n     = 1'b0;
    src_reg1  = '0;
    src_reg2  = '0;
    dst_reg   = '0;
    write_reg = 1'b0;
    wb_sel    = 1'b0;
    dst_data  = '0;
    op        = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      src_reg1 = 4'(i);
      src_reg2 = 4'(15 - i);
      #1;
      check("rst_rd1", src_data1, 16'h0000);
      check("rst_rd2", src_data2, 16'h0000);
      check("rst_res", exec_result, 16'h0000);
      check("rst_err", {15'b0, exec_error}, 16'h0000);
    end

    wr(4'd3, 16'h1234);
    src_reg1 = 4'd3;
    #1;
    check("wr_r3", src_data1, 16'h1234);

    // Same-cycle bypass on both ports.
    src_reg2  = 4'd3;
    dst_reg   = 4'd3;
    dst_data  = 16'hABCD;
    write_reg = 1'b1;
    #1;
    check("byp_rd1", src_data1, 16'hABCD);
    check("byp_rd2", src_data2, 16'hABCD);
    @(posedge clk);
    #1;
    write_reg = 1'b0;
    check("byp_kept", src_data1, 16'hABCD);

    src_reg1  = 4'd0;
    dst_reg   = 4'd0;
    dst_data  = 16'hFFFF;
    write_reg = 1'b1;
    #1;
    check("r0_nobyp", src_data1, 16'h0000);
    @(posedge clk);
    #1;
    write_reg = 1'b0;
    check("r0_zero", src_data1, 16'h0000);

    alu_chk("add_pos_sat", 16'h7FFF, 16'h0001, 3'b000, 16'h7FFF, 1'b1);
    alu_chk("add_neg_sat", 16'h8800, 16'h8901, 3'b000, 16'h8000, 1'b1);
    alu_chk("add_plain",   16'h0003, 16'h0004, 3'b000, 16'h0007, 1'b0);
    alu_chk("sub_neg_sat", 16'h8000, 16'h0001, 3'b001, 16'h8000, 1'b1);
    alu_chk("sub_pos_sat", 16'h7FFF, 16'hFFFF, 3'b001, 16'h7FFF, 1'b1);
    alu_chk("sub_plain",   16'h0005, 16'h0007, 3'b001, 16'hFFFE, 1'b0);
    alu_chk("nand",        16'hF0F0, 16'hFF00, 3'b010, 16'h0FFF, 1'b0);
    alu_chk("xor",         16'hF0F0, 16'hFF00, 3'b011, 16'h0FF0, 1'b0);
    alu_chk("red_11",      16'h1111, 16'h1111, 3'b100, 16'h0044, 1'b0);
    alu_chk("red_7f",      16'h7F7F, 16'h7F7F, 3'b100, 16'h01FC, 1'b0);
    alu_chk("red_80",      16'h8080, 16'h8080, 3'b100, 16'hFE00, 1'b0);
    alu_chk("red_00",      16'h0000, 16'h0000, 3'b100, 16'h0000, 1'b0);
    alu_chk("rsv_111",     16'h7FFF, 16'h0001, 3'b111, 16'h0000, 1'b0);
    alu_chk("rsv_101",     16'h1234, 16'h5678, 3'b101, 16'h0000, 1'b0);

    // Result write-back: R1=7FFF + R2=0001 saturates into R4.
    wr(4'd1, 16'h7FFF);
    wr(4'd2, 16'h0001);
    src_reg1  = 4'd1;
    src_reg2  = 4'd2;
    op        = 3'b000;
    dst_reg   = 4'd4;
    wb_sel    = 1'b1;
    write_reg = 1'b1;
    @(posedge clk);
    #1;
    write_reg = 1'b0;
    wb_sel    = 1'b0;
    src_reg1  = 4'd4;
    #1;
    check("wb_r4", src_data1, 16'h7FFF);

    // Result write-back to a source register reads the stored value, not the result.
    wr(4'd1, 16'h0003);
    wr(4'd2, 16'h0004);
    src_reg1  = 4'd1;
    src_reg2  = 4'd2;
    dst_reg   = 4'd1;
    wb_sel    = 1'b1;
    write_reg = 1'b1;
    #1;
    check("wb_nobyp_rd", src_data1, 16'h0003);
    check("wb_nobyp_res", exec_result, 16'h0007);
    @(posedge clk);
    #1;
    write_reg = 1'b0;
    wb_sel    = 1'b0;
    check("wb_r1_new", src_data1, 16'h0007);
    check("wb_res_new", exec_result, 16'h000B);

    // Reset wins over a simultaneous write.
    rst_n     = 1'b0;
    dst_reg   = 4'd5;
    dst_data  = 16'h5555;
    write_reg = 1'b1;
    src_reg1  = 4'd5;
    src_reg2  = 4'd3;
    #1;
    check("rst_nobyp", src_data1, 16'h0000);
    @(posedge clk);
    #1;
    write_reg = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("rst_pri_r5", src_data1, 16'h0000);
    check("rst_clr_r3", src_data2, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_exec_unit.md
Name: regfile_exec_unit

Overview:
- 16 x 16-bit register file with two combinational read ports and one synchronous write port.
- A combinational execute stage feeds off the two read ports: saturating ADD/SUB, NAND, XOR and the byte-reduction RED.
- The write port takes either external data or the execute result.
- Sits at the register-read/execute boundary of the single-cycle datapath.

Parameters:
- DATA_W, 16, datapath width; all arithmetic rules below assume 16.
- REG_CNT, 16, number of architectural registers; address width is 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- src_reg1  in  4  read address, port 1.
- src_reg2  in  4  read address, port 2.
- dst_reg  in  4  write address.
- write_reg  in  1  write enable.
- wb_sel  in  1  write-data select: 0 = dst_data, 1 = exec_result.
- dst_data  in  16  external write data.
- op  in  3  execute opcode: 000 ADD, 001 SUB, 010 NAND, 011 XOR, 100 RED; 101-111 reserved.
- src_data1  out  16  read data, port 1.
- src_data2  out  16  read data, port 2.
- exec_result  out  16  execute result computed from src_data1 (A) and src_data2 (B).
- exec_error  out  1  saturating-overflow flag.

Behaviour:
- Reset: on a rising clk with rst_n=0, all 16 registers become 0000. Reset has priority over any write in the same cycle. After reset, src_data1, src_data2 and exec_result read 0000 for any address with op=ADD, and exec_error=0.
- R0 is hardwired: it always reads 0000, and writes to R0 are ignored.
- Write: on a rising clk with rst_n=1, write_reg=1 and dst_reg!=0, reg[dst_reg] takes the selected write data (wd).
- Reads are combinational, zero latency.
- Write-before-read bypass: if write_reg=1, rst_n=1, dst_reg!=0 and dst_reg==src_regN, then src_dataN = wd in that same cycle.
- Bypass loop: wb_sel=1 with bypass active would close a combinational loop. wb_sel=1 bypass is therefore disabled; the register value is returned instead.
- ADD: 16-bit two's-complement A+B, saturating.
  - Positive overflow gives 7FFF; negative overflow gives 8000.
  - exec_error=1 exactly when saturation occurs.
- SUB: A-B computed as A+~B+1, with the same saturation and flag rules as ADD.
- NAND: ~(A&B). XOR: A^B. exec_error=0 for both.
- RED: A={a1,a0}, B={b1,b0} (bytes).
  - Result = sign-extend-to-16 of ((a1+b1)+(a0+b0)).
  - Each byte sum is 9-bit signed; the total is 10-bit signed.
  - Unsigned/signed interpretation: the bytes are signed.
  - exec_error=0.
- Reserved op: exec_result=0000, exec_error=0.
- Simultaneous write to a register and read of the same register: the bypass rule applies.

Decomposition:
- Shared package holds: DATA_W, REG_CNT, REG_ADDR_W=4, the op_t enum (OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_RED), and the SAT_POS=16'h7FFF / SAT_NEG=16'h8000 constants.
- One sub-module, exec_alu: purely combinational. Inputs A, B, op; outputs exec_result, exec_error.
- The register array and bypass stay in the top.

Test Plan:
- Reset: rst_n=0 for one edge, then read all 16 addresses -> every src_data = 0000 and exec_error=0.
- Write then read back:
  - Write R3=1234 (wb_sel=0), then read src_reg1=3 -> 1234.
  - Same-cycle read of R3 while writing ABCD -> ABCD (bypass).
  - Write R0=FFFF -> R0 still reads 0000.
- Saturating add/sub:
  - 7FFF+0001 -> 7FFF, error=1.
  - 8800+8901 -> 8000, error=1.
  - 0003+0004 -> 0007, error=0.
  - SUB 8000-0001 -> 8000, error=1.
- Logic ops: NAND F0F0,FF00 -> 0FFF; XOR F0F0,FF00 -> 0FF0; error=0 for both.
- RED:
  - 1111,1111 -> 0044.
  - 7F7F,7F7F -> 01FC.
  - 8080,8080 -> FE00.
  - 0000,0000 -> 0000.
  - exec_error=0 in every case.
- Write-back of execute result: R1=7FFF, R2=0001, op=ADD, wb_sel=1, dst_reg=4 -> after the edge R4=7FFF. Reserved op=111 -> exec_result=0000.
